inst_axi_rbridge: RTL

- Instruction-side bridge between the fetch stage's SRAM-like master port and a single-beat AXI4 read channel.
- Converts each accepted `inst_sram_req` into one AR transaction and returns R beats as `inst_sram_data_ok`/`inst_sram_rdata`.
- Read-only; the fetch stage never writes.
- Sits between the fetch stage and the top-level AXI crossbar.

---
 rtl/inst_axi_rbridge.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/inst_axi_rbridge.sv
// ============================================================================
// inst_axi_rbridge
// ----------------------------------------------------------------------------
// Instruction-side bridge. It turns the fetch stage's SRAM-like request port
// into single-beat AXI4 read transactions (arlen = 0, INCR) and returns each
// R beat one cycle later as inst_sram_data_ok / inst_sram_rdata.
// The path is read-only. Write-related inputs are accepted but ignored, and no
// write channel exists.
//
// Optional build macro:
//   INST_BRIDGE_RRESP_CHK_EN - builds response checking. inst_sram_data_err
//                              flags SLVERR/DECERR responses. A sticky flag
//                              also reports every response that follows an
//                              unsolicited beat or a beat with a foreign ID.
//                              When the macro is undefined, data_err is tied
//                              to 0.
//
// Parameters:
//   ARID            - fixed AXI read ID driven on arid
//   MAX_OUTSTANDING - accepted-but-unreturned request limit (1..15)
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   inst_sram_req         - fetch request valid
//   inst_sram_wr/wstrb/wdata - ignored (every request is a read)
//   inst_sram_size        - 0/1/2 = 1/2/4 bytes
//   inst_sram_addr        - byte address
//   inst_sram_addr_ok     - request accepted this cycle (combinational)
//   inst_sram_data_ok     - read data valid this cycle (registered)
//   inst_sram_rdata       - read data, holds between responses
//   inst_sram_data_err    - response error flag
//   ar*                   - AXI read address channel (master side)
//   r*                    - AXI read data channel (master side, rready = 1)
// ============================================================================
module inst_axi_rbridge #(
    parameter logic [3:0] ARID            = 4'd0,
    parameter int         MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    // fetch-stage SRAM-like port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_data_err,
    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    // AR state machine: IDLE waits for a request, ADDR presents it on AR.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ADDR = 1'b1;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [0:0] state;
    logic [3:0] cnt;        // accepted requests whose R beat has not returned
    logic [1:0] size_q;
    logic       r_hs;
    logic       cnt_inc;
    logic       cnt_dec;

    // ------------------------------------------------------------------
    // Constant AR fields and the always-ready R channel
    // ------------------------------------------------------------------
    assign arid    = ARID;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign rready  = 1'b1;

    assign arvalid = (state == S_ADDR);
    assign arsize  = {1'b0, size_q};

    // The registered cnt is used here. A returning beat therefore unblocks
    // acceptance one cycle later, never in the same cycle.
    assign inst_sram_addr_ok = inst_sram_req && (state == S_IDLE) && (cnt < MAX_CNT);

    assign r_hs    = rvalid && rready && rlast;
    assign cnt_inc = inst_sram_addr_ok;
    // A beat that arrives with nothing outstanding is a protocol error. It
    // must not wrap the counter.
    assign cnt_dec = r_hs && (cnt != 4'd0);

    // ------------------------------------------------------------------
    // AR channel: latch on accept, hold until the handshake
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking (<=) assignments. All
    // registers then update from the same pre-edge values, and no ordering
    // race can occur between always_ff blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            araddr <= 32'd0;
            size_q <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inst_sram_addr_ok) begin
                        state  <= S_ADDR;
                        araddr <= inst_sram_addr;
                        size_q <= inst_sram_size;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outstanding counter. When an accept and a return coincide, the
    // counter holds its value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered R return path
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= 32'd0;
        end else begin
            inst_sram_data_ok <= r_hs;
            if (r_hs) begin
                inst_sram_rdata <= rdata;
            end
        end
    end

`ifdef INST_BRIDGE_RRESP_CHK_EN
    // The sticky flag records a protocol violation: a beat that arrives
    // with nothing outstanding, or a beat with the wrong ID. It sets on the
    // offending beat and affects every response that follows, until reset.
    logic err_sticky;
    logic unused_inputs;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky         <= 1'b0;
            inst_sram_data_err <= 1'b0;
        end else begin
            inst_sram_data_err <= r_hs && (rresp[1] || err_sticky);
            if (r_hs && ((cnt == 4'd0) || (rid != ARID))) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp[0]};
`else
    logic unused_inputs;

    assign inst_sram_data_err = 1'b0;
    assign unused_inputs      = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp};
`endif

endmodule
